jk_bank_ctrl: RTL and testbench
===============================

Name: jk_bank_ctrl

Overview:
- Pushbutton-driven controller that sequences a bank of NBITS JK-style storage bits.
- The user selects one bit with its select button. A J press, a K press, or both within a settle window then sets, clears or toggles that bit.
- The block sits between the raw pb inputs and the left/right LED outputs.
- It handles synchronisation, arbitration between simultaneous selects, J/K coincidence detection and release-wait.

Parameters:
- NBITS, 8, number of controlled bits (2..16).
- SETTLE_CYC, 3, cycles during which J and K presses are OR-accumulated before the operation is applied (>=1).
- IDXW, $clog2(NBITS), localparam, width of the bit index.

Ports:
- clk  input  1  system clock (hz100 at top level).
- n_rst  input  1  asynchronous active-low reset.
- sel_pb  input  NBITS  raw select buttons, one per bit.
- j_pb  input  1  raw J button.
- k_pb  input  1  raw K button.
- q  output  NBITS  controlled bit bank.
- sel_idx  output  IDXW  currently captured bit index.
- busy  output  1  high whenever the FSM is not in IDLE.
- err  output  1  high if the last capture saw more than one select asserted.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, n_rst). On n_rst low, immediately:
  - q=0, sel_idx=0, err=0, state=IDLE;
  - settle counter=0, accumulators=0;
  - all synchronizer flops=0.
- Reset mid-operation aborts the operation with no q change.
- Synchronisation: sel_pb, j_pb and k_pb each pass through a 2-flop synchronizer. The FSM uses only the synchronized signals (sel_s, j_s, k_s).
- FSM states are IDLE, ARMED, SETTLE, APPLY and WAIT_REL.
- IDLE:
  - j_s/k_s are ignored.
  - If sel_s != 0: sel_idx <= lowest set index; err <= (more than one bit set); go to ARMED.
- ARMED:
  - If sel_s has a set bit whose lowest index differs from sel_idx, recapture sel_idx and err the same way, and stay in ARMED.
  - Else, if j_s|k_s: go to SETTLE with cnt=0, jacc<=j_s, kacc<=k_s.
  - Op buttons are level-sensitive here: holding J before selecting proceeds immediately.
- SETTLE:
  - Each cycle: jacc|=j_s, kacc|=k_s, cnt++.
  - When cnt==SETTLE_CYC-1, go to APPLY.
  - sel_s is ignored.
- APPLY (exactly one cycle). On the exit edge, q[sel_idx] updates as follows:
  - jacc&kacc: toggle;
  - jacc only: set to 1;
  - kacc only: clear to 0.
  - Other q bits are unchanged. Then go to WAIT_REL.
- WAIT_REL: stay until sel_s==0, j_s==0 and k_s==0, then go to IDLE. This guarantees one operation per press.
- Latency: raw j_pb rising before edge N gives q updated at edge N+3+SETTLE_CYC (N+6 at default). busy rises one edge after sel_s first rises.
- err is held until the next capture; it does not pulse.
- Simultaneous selects: the lowest index wins.
- J/K arriving in different cycles within the window counts as toggle.
- A J or K edge arriving after the window is ignored until release.
- Wrap-around is not applicable; sel_idx is always < NBITS.

Decomposition:
- Package jk_ctrl_pkg:
  - enum state_t {IDLE, ARMED, SETTLE, APPLY, WAIT_REL};
  - enum op_t {OP_NONE, OP_SET, OP_CLR, OP_TGL};
  - function lowest_set(), returning the index of the lowest set bit.
- Sub-module pb_sync: parametric-width 2-flop synchronizer with the same clk/n_rst. Instantiate it once at width NBITS+2.

Test Plan:
- Reset: drive buttons randomly, assert n_rst=0 asynchronously mid-cycle -> q=0, sel_idx=0, err=0, busy=0 immediately, before the next clk edge.
- Set: press sel_pb=8'h08, then j_pb high before edge N -> sel_idx=3, q=8'h08 at edge N+6. With buttons held, q stays at 8'h08 and busy=1. After release, busy=0 within 3 edges.
- Clear plus arbitration: starting from q=8'hFF, press sel_pb=8'h24 -> sel_idx=2, err=1. Then press k_pb -> q=8'hFB, and bit 5 is untouched.
- Toggle with skew: select bit 0, j_pb at edge N, k_pb at edge N+2 -> q[0] toggles 0->1. Repeating the sequence toggles 1->0. Repeat with k_pb at edge N+5 -> set only (q[0]=1).
- Reselect in ARMED: press sel bit 6, release, press sel bit 1, then J -> only q[1]=1 and sel_idx=1. J held in IDLE with no select -> no q change, busy=0.
- Abort: pulse n_rst=0 during SETTLE -> q unchanged from its reset value 0. After release, an idle bench with buttons low stays in IDLE.

Source files
------------

// File: rtl/jk_ctrl_pkg.sv
// Shared types and helpers for the pushbutton-driven JK bit bank controller.
package jk_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETTLE,
    APPLY,
    WAIT_REL
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_SET,
    OP_CLR,
    OP_TGL
  } op_t;

  // Helpers work on the widest supported bank; callers zero-extend.
  localparam int MAX_NBITS = 16;

  function automatic int lowest_set(input logic [MAX_NBITS-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_NBITS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic multi_set(input logic [MAX_NBITS-1:0] v);
    return (v & (v - MAX_NBITS'(1))) != '0;
  endfunction

  function automatic op_t decode_op(input logic j, input logic k);
    op_t op;
    case ({j, k})
      2'b11:   op = OP_TGL;
      2'b10:   op = OP_SET;
      2'b01:   op = OP_CLR;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/pb_sync.sv
// Parametric-width two-flop synchronizer for raw pushbutton inputs.
module pb_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Select-then-J/K controller for a bank of NBITS storage bits with settle window
// and release-wait so each press applies exactly one operation.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter  int NBITS      = 8,
  parameter  int SETTLE_CYC = 3,
  localparam int IDXW       = $clog2(NBITS)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [NBITS-1:0] sel_pb,
  input  logic             j_pb,
  input  logic             k_pb,
  output logic [NBITS-1:0] q,
  output logic [IDXW-1:0]  sel_idx,
  output logic             busy,
  output logic             err
);

  localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [NBITS-1:0]     sel_s;
  logic                 j_s;
  logic                 k_s;
  logic [MAX_NBITS-1:0] sel_w;
  logic [IDXW-1:0]      low_idx;
  logic                 low_multi;
  logic                 sel_any;
  op_t                  op;

  state_t               state;
  logic [CNTW-1:0]      cnt;
  logic                 jacc;
  logic                 kacc;

  pb_sync #(.W(NBITS + 2)) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     ({k_pb, j_pb, sel_pb}),
    .q     ({k_s, j_s, sel_s})
  );

  assign sel_w     = MAX_NBITS'(sel_s);
  assign low_idx   = IDXW'(lowest_set(sel_w));
  assign low_multi = multi_set(sel_w);
  assign sel_any   = |sel_s;
  assign op        = decode_op(jacc, kacc);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      q       <= '0;
      sel_idx <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      jacc    <= 1'b0;
      kacc    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            sel_idx <= low_idx;
            err     <= low_multi;
            state   <= ARMED;
          end
        end
        ARMED: begin
          // A different select wins over a pending op press in the same cycle.
          if (sel_any && (low_idx != sel_idx)) begin
            sel_idx <= low_idx;
            err     <= low_multi;
          end else if (j_s || k_s) begin
            cnt   <= '0;
            jacc  <= j_s;
            kacc  <= k_s;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          jacc <= jacc | j_s;
          kacc <= kacc | k_s;
          cnt  <= cnt + CNTW'(1);
          if (cnt == CNTW'(SETTLE_CYC - 1)) state <= APPLY;
        end
        APPLY: begin
          case (op)
            OP_SET:  q[sel_idx] <= 1'b1;
            OP_CLR:  q[sel_idx] <= 1'b0;
            OP_TGL:  q[sel_idx] <= ~q[sel_idx];
            default: q[sel_idx] <= q[sel_idx];
          endcase
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          if (!sel_any && !j_s && !k_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: operation table run through a q scoreboard, plus
// hand sequences for async reset, abort, reselect and idle J presses.
module tb_jk_bank_ctrl;

  localparam int NBITS = 8;
  localparam int IDXW  = 3;

  logic             clk;
  logic             n_rst;
  logic [NBITS-1:0] sel_pb;
  logic             j_pb;
  logic             k_pb;
  logic [NBITS-1:0] q;
  logic [IDXW-1:0]  sel_idx;
  logic             busy;
  logic             err;

  typedef struct {
    logic [NBITS-1:0] sel;
    logic             j;
    logic             k;
    int               kskew;
    logic [NBITS-1:0] q;
    logic [IDXW-1:0]  idx;
    logic             err;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] prev_q;
  int checks;
  int errors;

  jk_bank_ctrl #(.NBITS(NBITS), .SETTLE_CYC(3)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .sel_pb  (sel_pb),
    .j_pb    (j_pb),
    .k_pb    (k_pb),
    .q       (q),
    .sel_idx (sel_idx),
    .busy    (busy),
    .err     (err)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [NBITS-1:0] sel, input logic j, input logic k,
                              input int kskew, input logic [NBITS-1:0] qv,
                              input logic [IDXW-1:0] idx, input logic e);
    vec_t v;
    v.sel = sel; v.j = j; v.k = k; v.kskew = kskew;
    v.q = qv; v.idx = idx; v.err = e;
    return v;
  endfunction

  task automatic release_all();
    sel_pb = '0;
    j_pb   = 1'b0;
    k_pb   = 1'b0;
  endtask

  // Select, then press J/K with the first op button raw before edge N and K
  // (when combined with J) raw before edge N+kskew; q must move at edge N+6.
  task automatic run_op(input vec_t v);
    logic [NBITS-1:0] exp;
    @(negedge clk);
    sel_pb = v.sel;
    repeat (3) @(posedge clk);
    #1;
    check("sel_idx", 32'(sel_idx), 32'(v.idx));
    check("err", 32'(err), 32'(v.err));
    check("busy_armed", 32'(busy), 32'd1);
    exp_q.push_back(v.q);
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      if (e == 0 && v.j) j_pb = 1'b1;
      if (v.k && ((v.j && e == v.kskew) || (!v.j && e == 0))) k_pb = 1'b1;
      @(posedge clk);
      if (e == 5) begin
        #1;
        check("q_before_apply", 32'(q), 32'(prev_q));
      end
    end
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check("q_apply", 32'(q), 32'(exp));
    end
    repeat (2) @(posedge clk);
    #1;
    check("q_held", 32'(q), 32'(v.q));
    check("busy_held", 32'(busy), 32'd1);
    @(negedge clk);
    release_all();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check("busy_release", 32'(busy), 32'd0);
    prev_q = v.q;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    prev_q = '0;

    vecs[0]  = mk(8'h08, 1'b1, 1'b0, 0, 8'h08, 3'd3, 1'b0);
    vecs[1]  = mk(8'h01, 1'b1, 1'b0, 0, 8'h09, 3'd0, 1'b0);
    vecs[2]  = mk(8'h02, 1'b1, 1'b0, 0, 8'h0B, 3'd1, 1'b0);
    vecs[3]  = mk(8'h04, 1'b1, 1'b0, 0, 8'h0F, 3'd2, 1'b0);
    vecs[4]  = mk(8'h10, 1'b1, 1'b0, 0, 8'h1F, 3'd4, 1'b0);
    vecs[5]  = mk(8'h20, 1'b1, 1'b0, 0, 8'h3F, 3'd5, 1'b0);
    vecs[6]  = mk(8'h40, 1'b1, 1'b0, 0, 8'h7F, 3'd6, 1'b0);
    vecs[7]  = mk(8'h80, 1'b1, 1'b0, 0, 8'hFF, 3'd7, 1'b0);
    vecs[8]  = mk(8'h24, 1'b0, 1'b1, 0, 8'hFB, 3'd2, 1'b1);
    vecs[9]  = mk(8'h01, 1'b0, 1'b1, 0, 8'hFA, 3'd0, 1'b0);
    vecs[10] = mk(8'h01, 1'b1, 1'b1, 2, 8'hFB, 3'd0, 1'b0);
    vecs[11] = mk(8'h01, 1'b1, 1'b1, 2, 8'hFA, 3'd0, 1'b0);
    vecs[12] = mk(8'h01, 1'b1, 1'b1, 5, 8'hFB, 3'd0, 1'b0);
    vecs[13] = mk(8'h01, 1'b1, 1'b1, 0, 8'hFA, 3'd0, 1'b0);
    vecs[14] = mk(8'h03, 1'b0, 1'b1, 0, 8'hFA, 3'd0, 1'b1);
    vecs[15] = mk(8'h81, 1'b1, 1'b1, 1, 8'hFB, 3'd0, 1'b1);
    vecs[16] = mk(8'h80, 1'b0, 1'b1, 0, 8'h7B, 3'd7, 1'b0);

    // Power-on reset
    release_all();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Random button activity, then async reset mid-cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sel_pb = NBITS'($urandom_range(0, 255));
      j_pb   = 1'($urandom_range(0, 1));
      k_pb   = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_sel_idx", 32'(sel_idx), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    release_all();
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_rst", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) run_op(vecs[i]);

    // Abort: reset pulse while the FSM is settling
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    prev_q = '0;
    sel_pb = 8'h08;
    repeat (3) @(posedge clk);
    @(negedge clk);
    j_pb = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    release_all();
    #2;
    check("abort_q_now", 32'(q), 32'd0);
    check("abort_busy_now", 32'(busy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_q_later", 32'(q), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // Reselect in ARMED: bit 6, release, then bit 1 with J
    @(negedge clk);
    sel_pb = 8'h40;
    repeat (3) @(posedge clk);
    #1;
    check("resel_first_idx", 32'(sel_idx), 32'd6);
    @(negedge clk);
    sel_pb = '0;
    repeat (4) @(posedge clk);
    #1;
    check("resel_still_armed", 32'(busy), 32'd1);
    check("resel_idx_kept", 32'(sel_idx), 32'd6);
    run_op(mk(8'h02, 1'b1, 1'b0, 0, 8'h02, 3'd1, 1'b0));

    // J held with no select must do nothing
    @(negedge clk);
    j_pb = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("j_idle_busy", 32'(busy), 32'd0);
    check("j_idle_q", 32'(q), 32'h02);
    @(negedge clk);
    release_all();
    repeat (3) @(posedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
